// File: rtl/freq_scan_pkg.sv
// Shared types and helpers for the frequency scan controller.
// Latency: n/a (types, constants and a combinational helper function only).
// Backpressure: n/a.
// Contents: scan FSM state enum, default channel count / result width,
//           and the round-robin next-channel priority search.
package freq_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_NEXT
    } state_t;

    localparam int NCH_DEF = 8;
    localparam int CW_DEF  = 24;
    localparam int MAX_CH  = 32;

    // Returns the first set mask bit strictly above cur, wrapping around
    // through bit 0. With a single set bit equal to cur, cur itself comes
    // back after a full lap. Passing cur = nch-1 yields the lowest set bit.
    // With an empty mask cur is returned unchanged.
    function automatic int unsigned next_ch(input logic [MAX_CH-1:0] mask,
                                            input int unsigned        cur,
                                            input int unsigned        nch);
        int unsigned idx;
        logic        found;
        next_ch = cur;
        found   = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = cur + i;
            if (idx >= nch) begin
                idx = idx - nch;
            end
            if (!found && (i <= nch) && mask[idx[4:0]]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Single-bit 2-flop synchronizer followed by a registered rising-edge detector.
// Latency: o_rise pulses 3 clk_clk cycles after a rising transition on i_sig.
// Backpressure: none; free-running, one-cycle pulse per detected edge.
// Ports: i_clk (clock), i_rst (async active-high reset), i_sig (async input),
//        o_rise (one-cycle rising-edge strobe, clock domain of i_clk).
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Registered so the counter sees a clean flop output.
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Time-shared frequency counter: scans ch_mask channels, counting rising edges per gate window.
// Latency: one result per SETTLE_CYCLES + GATE_CYCLES + 2 cycles; done_pulse follows STORE by one edge.
// Backpressure: none; results overwrite freq_flat slices, enable=0 aborts the current measurement.
// Ports: clk_clk/reset_reset (clock, async active-high reset), enable (run/stop),
//        ch_mask (channels to scan), sig_in (async inputs), freq_flat (packed per-channel counts),
//        ovf (per-channel saturation), done_pulse/done_ch (result strobe + channel), busy (not IDLE).
module freq_scan_ctrl
    import freq_scan_pkg::*;
#(
    parameter  int NCH           = NCH_DEF,
    parameter  int CW            = CW_DEF,
    parameter  int GATE_CYCLES   = 5_000_000,
    parameter  int SETTLE_CYCLES = 16,
    localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH-1:0]    sig_in,
    output logic [NCH*CW-1:0] freq_flat,
    output logic [NCH-1:0]    ovf,
    output logic              done_pulse,
    output logic [CHW-1:0]    done_ch,
    output logic              busy
);

    // One timer serves both the settle and gate windows.
    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CHW-1:0]      r_ch;
    logic [TW-1:0]       r_tmr;
    logic [CW-1:0]       r_cnt;
    logic                r_sat;
    logic [NCH-1:0]      w_rise;
    logic [MAX_CH-1:0]   w_mask_ext;
    logic                w_settle_done;
    logic                w_gate_done;
    logic                w_tmr_run;
    logic                w_cnt_run;
    logic                w_store;
    logic                w_sel_load;
    logic [CHW-1:0]      w_sel_nxt;
    int unsigned         w_search_from;

    // Per-channel synchronizer + edge detector; all run continuously so a
    // channel's pipeline is already primed when it gets selected.
    for (genvar g = 0; g < NCH; g++) begin : g_sync
        sync_edge_det u_sync (
            .i_clk  (clk_clk),
            .i_rst  (reset_reset),
            .i_sig  (sig_in[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_mask_ext    = MAX_CH'(ch_mask);
    assign w_settle_done = (r_state == ST_SETTLE) && (r_tmr == TW'(SETTLE_CYCLES - 1));
    assign w_gate_done   = (r_state == ST_GATE)   && (r_tmr == TW'(GATE_CYCLES - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (|ch_mask) w_state_nxt = ST_SETTLE;
                ST_SETTLE: if (w_settle_done) w_state_nxt = ST_GATE;
                ST_GATE:   if (w_gate_done) w_state_nxt = ST_STORE;
                ST_STORE:  w_state_nxt = ST_NEXT;
                ST_NEXT:   w_state_nxt = (|ch_mask) ? ST_SETTLE : ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / datapath controls ----------------
    always_comb begin
        busy          = (r_state != ST_IDLE);
        w_tmr_run     = (r_state == ST_SETTLE) || (r_state == ST_GATE);
        w_cnt_run     = (r_state == ST_GATE);
        w_store       = (r_state == ST_STORE) && enable;
        // ch_mask is only consulted when leaving IDLE or NEXT.
        w_sel_load    = (w_state_nxt == ST_SETTLE) &&
                        ((r_state == ST_IDLE) || (r_state == ST_NEXT));
        // From IDLE start the search just below bit 0 to get the lowest set bit.
        w_search_from = (r_state == ST_IDLE) ? 32'(NCH - 1) : 32'(r_ch);
        w_sel_nxt     = CHW'(next_ch(w_mask_ext, w_search_from, NCH));
    end

    // Channel select and window timer.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_ch  <= '0;
            r_tmr <= '0;
        end else begin
            if (w_sel_load) begin
                r_ch <= w_sel_nxt;
            end
            if (w_tmr_run && !w_settle_done && !w_gate_done && enable) begin
                r_tmr <= r_tmr + 1'b1;
            end else begin
                r_tmr <= '0;
            end
        end
    end

    // Shared edge counter; held at zero outside the gate window, so it is
    // already clear on gate entry.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (!w_cnt_run) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_rise[r_ch]) begin
            if (!(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Flag as soon as the count reaches (or is already at) full scale.
            if (&(r_cnt | CW'(1))) begin
                r_sat <= 1'b1;
            end
        end
    end

    // Result registers: only the selected slice is written at STORE.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            freq_flat  <= '0;
            ovf        <= '0;
            done_pulse <= 1'b0;
            done_ch    <= '0;
        end else begin
            done_pulse <= w_store;
            if (w_store) begin
                done_ch <= r_ch;
                for (int k = 0; k < NCH; k++) begin
                    if (r_ch == CHW'(k)) begin
                        freq_flat[k*CW +: CW] <= r_cnt;
                        ovf[k]                <= r_sat;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Self-checking bench for freq_scan_ctrl (GATE_CYCLES=100, SETTLE_CYCLES=4).
// Two instances share stimulus: CW=24 for nominal counts, CW=4 for saturation.
// Expected counts come from GATE/period arithmetic and a round-robin channel list.
module tb_freq_scan_ctrl;

    localparam int NCH  = 8;
    localparam int GATE = 100;
    localparam int SETL = 4;
    localparam int PER  = SETL + GATE + 2;

    logic              clk_clk;
    logic              reset_reset;
    logic              enable;
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    sig_in;
    logic [NCH*24-1:0] freq_flat;
    logic [NCH-1:0]    ovf;
    logic              done_pulse;
    logic [2:0]        done_ch;
    logic              busy;
    logic [NCH*4-1:0]  freq4;
    logic [NCH-1:0]    ovf4;
    logic              done4;
    logic [2:0]        done_ch4;
    logic              busy4;

    int unsigned per [NCH];
    int unsigned ph  [NCH];
    int          checks;
    int          errors;
    time         t_prev;

    freq_scan_ctrl #(.NCH(NCH), .CW(24), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETL)) u_dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .ch_mask(ch_mask),
        .sig_in(sig_in), .freq_flat(freq_flat), .ovf(ovf), .done_pulse(done_pulse),
        .done_ch(done_ch), .busy(busy));

    freq_scan_ctrl #(.NCH(NCH), .CW(4), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETL)) u_dut4 (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .ch_mask(ch_mask),
        .sig_in(sig_in), .freq_flat(freq4), .ovf(ovf4), .done_pulse(done4),
        .done_ch(done_ch4), .busy(busy4));

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    // Pulse generator: channel k is high for one cycle every per[k] cycles.
    initial begin
        int unsigned t;
        t      = 0;
        sig_in = '0;
        forever begin
            @(negedge clk_clk);
            for (int k = 0; k < NCH; k++) begin
                if (per[k] != 0) sig_in[k] = (((t + ph[k]) % per[k]) == 0);
                else             sig_in[k] = 1'b0;
            end
            t++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next done_pulse; a timeout counts as a failure.
    task automatic wait_done(input string name, output bit got);
        got = 1'b0;
        for (int c = 0; c < 3 * PER; c++) begin
            @(negedge clk_clk);
            if (done_pulse) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done_pulse", name);
        end
    endtask

    function automatic int exp_count(input int unsigned p);
        return (p == 0) ? 0 : GATE / int'(p);
    endfunction

    task automatic setup(input logic [NCH-1:0] m);
        enable = 1'b0;
        for (int k = 0; k < NCH; k++) per[k] = 0;
        ch_mask = m;
    endtask

    typedef struct {
        int          ch;
        int unsigned p;
        logic [23:0] exp24;
        logic [3:0]  exp4;
        logic        eovf4;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit          got;
        int          ord [$];
        int          exp_seq [4];
        logic [7:0]  m;
        int          nbusy, ndone, e;
        int unsigned plist [8];

        checks = 0;
        errors = 0;
        t_prev = 0;
        vecs[0] = '{0, 10, 24'd10, 4'd10, 1'b0};
        vecs[1] = '{3,  4, 24'd25, 4'hF,  1'b1};
        vecs[2] = '{3, 20, 24'd5,  4'd5,  1'b0};
        vecs[3] = '{5,  2, 24'd50, 4'hF,  1'b1};
        vecs[4] = '{6, 25, 24'd4,  4'd4,  1'b0};
        vecs[5] = '{7, 50, 24'd2,  4'd2,  1'b0};
        vecs[6] = '{1,  5, 24'd20, 4'hF,  1'b1};
        vecs[7] = '{2,  0, 24'd0,  4'd0,  1'b0};
        plist   = '{0, 2, 4, 5, 10, 20, 25, 50};

        for (int k = 0; k < NCH; k++) begin
            per[k] = 0;
            ph[k]  = 0;
        end
        reset_reset = 1'b1;
        enable      = 1'b0;
        ch_mask     = '0;
        repeat (3) @(negedge clk_clk);
        chk("rst_freq",  64'(freq_flat == '0), 1);
        chk("rst_ovf",   ovf, 0);
        chk("rst_done",  done_pulse, 0);
        chk("rst_donech", done_ch, 0);
        chk("rst_busy",  busy, 0);
        reset_reset = 1'b0;
        @(negedge clk_clk);

        // Table: single-channel measurements on both result widths.
        for (int i = 0; i < 8; i++) begin
            setup(8'(1 << vecs[i].ch));
            per[vecs[i].ch] = vecs[i].p;
            repeat (5) @(negedge clk_clk);
            enable = 1'b1;
            wait_done("vec_done", got);
            if (got) begin
                chk($sformatf("vec%0d_ch", i),   done_ch, 64'(vecs[i].ch));
                chk($sformatf("vec%0d_f24", i),  freq_flat[vecs[i].ch*24 +: 24], vecs[i].exp24);
                chk($sformatf("vec%0d_ovf24", i), ovf[vecs[i].ch], 0);
                chk($sformatf("vec%0d_f4", i),   freq4[vecs[i].ch*4 +: 4], vecs[i].exp4);
                chk($sformatf("vec%0d_ovf4", i), ovf4[vecs[i].ch], vecs[i].eovf4);
            end
            enable = 1'b0;
            @(negedge clk_clk);
        end

        // Single channel steady scan: result every PER cycles.
        setup(8'h01);
        per[0] = 10;
        repeat (5) @(negedge clk_clk);
        enable = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_done("single_done", got);
            if (got) begin
                if (j > 0) chk("single_spacing", ($time - t_prev) / 10, PER);
                t_prev = $time;
                chk("single_ch", done_ch, 0);
                chk("single_val", freq_flat[23:0], 10);
            end
        end

        // Mask change mid-measurement only affects the following selection.
        per[4] = 5;
        repeat (20) @(negedge clk_clk);
        ch_mask = 8'h10;
        wait_done("mask_hold_done", got);
        if (got) begin
            chk("mask_hold_ch", done_ch, 0);
            chk("mask_hold_val", freq_flat[23:0], 10);
        end
        wait_done("mask_new_done", got);
        if (got) begin
            chk("mask_new_ch", done_ch, 4);
            chk("mask_new_val", freq_flat[4*24 +: 24], 20);
        end

        // Rotation between channels 2 and 7.
        setup(8'h84);
        per[2] = 10;
        per[7] = 5;
        exp_seq = '{2, 7, 2, 7};
        repeat (5) @(negedge clk_clk);
        enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_done("rot_done", got);
            if (got) begin
                if (j > 0) chk("rot_spacing", ($time - t_prev) / 10, PER);
                t_prev = $time;
                chk($sformatf("rot%0d_ch", j), done_ch, 64'(exp_seq[j]));
            end
        end
        chk("rot_ch7_slice", freq_flat[191:168], 20);
        chk("rot_ch2_slice", freq_flat[71:48], 10);

        // Abort mid-gate: prior ch0 result (10) must survive.
        setup(8'h01);
        per[0] = 20;
        repeat (5) @(negedge clk_clk);
        enable = 1'b1;
        repeat (SETL + 1 + 50) @(negedge clk_clk);
        chk("abort_busy_before", busy, 1);
        enable = 1'b0;
        @(negedge clk_clk);
        chk("abort_busy_after", busy, 0);
        ndone = 0;
        repeat (2 * PER) begin
            @(negedge clk_clk);
            if (done_pulse) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_hold", freq_flat[23:0], 10);

        // Reset mid-gate of ch2; restart must begin at ch1, not continue to ch7.
        setup(8'h86);
        per[1] = 10;
        per[2] = 5;
        per[7] = 4;
        repeat (5) @(negedge clk_clk);
        enable = 1'b1;
        wait_done("rst_first_done", got);
        if (got) chk("rst_first_ch", done_ch, 1);
        repeat (60) @(negedge clk_clk);
        chk("rst_mid_busy_before", busy, 1);
        reset_reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_freq", 64'(freq_flat == '0), 1);
        chk("rst_mid_ovf", ovf, 0);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        wait_done("rst_resume_done", got);
        if (got) begin
            chk("rst_resume_ch", done_ch, 1);
            chk("rst_resume_val", freq_flat[1*24 +: 24], 10);
        end

        // Empty mask stays idle.
        setup(8'h00);
        enable = 1'b1;
        nbusy  = 0;
        ndone  = 0;
        repeat (1000) begin
            @(negedge clk_clk);
            if (busy) nbusy++;
            if (done_pulse) ndone++;
        end
        chk("empty_busy", nbusy, 0);
        chk("empty_done", ndone, 0);

        // Randomized scans against the round-robin / GATE-per-period model.
        for (int it = 0; it < 6; it++) begin
            enable = 1'b0;
            m = 8'($urandom_range(1, 255));
            for (int k = 0; k < NCH; k++) begin
                per[k] = plist[$urandom_range(0, 7)];
                ph[k]  = $urandom_range(0, 49);
            end
            ch_mask = m;
            ord.delete();
            for (int k = 0; k < NCH; k++) if (m[k]) ord.push_back(k);
            repeat (5) @(negedge clk_clk);
            enable = 1'b1;
            for (int j = 0; j <= ord.size(); j++) begin
                wait_done("rnd_done", got);
                if (!got) break;
                if (j > 0) chk("rnd_spacing", ($time - t_prev) / 10, PER);
                t_prev = $time;
                e = exp_count(per[ord[j % ord.size()]]);
                chk($sformatf("rnd%0d_ch", it), done_ch, 64'(ord[j % ord.size()]));
                chk($sformatf("rnd%0d_f24", it), freq_flat[ord[j % ord.size()]*24 +: 24], 64'(e));
                chk($sformatf("rnd%0d_f4", it), freq4[ord[j % ord.size()]*4 +: 4],
                    64'((e > 15) ? 15 : e));
                chk($sformatf("rnd%0d_ovf4", it), ovf4[ord[j % ord.size()]], 64'(e >= 15));
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge clk_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
